// File: rtl/exe_mem_req_unit.sv
// exe_mem_req_unit
// Issues the data-memory request for a load/store sitting in the EXE stage.
// A valid memory op becomes exactly one SRAM-like request. The request is held
// until the bus accepts it with addr_ok. Byte strobes and replicated write data
// are generated for any XLEN (32 or 64).
// The block also tracks accepted-but-unanswered requests, flags misaligned or
// illegal-size accesses (ale), and cancels requests that a flush overtook.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   es_valid/es_mem_en    EXE holds a valid load/store
//   es_mem_we, es_size    store flag, access size (0=B 1=H 2=W 3=D)
//   es_addr, es_st_data   effective address and store source value
//   es_leave, flush       instruction leaves EXE / is killed this cycle
//   mem_ready_go          EXE may advance
//   ale                   address-alignment / illegal-size exception
//   data_sram_*           SRAM-like request bus (req/wr/size/addr/wstrb/wdata,
//                         addr_ok and data_ok handshakes)
//   ms_addr_lo            address LSBs forwarded to MEM for load extraction
//   req_cancel            1-cycle pulse: MEM drops the next unclaimed response
//   outst_cnt             accepted requests still awaiting data_ok
module exe_mem_req_unit #(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          es_valid,
  input  logic                          es_mem_en,
  input  logic                          es_mem_we,
  input  logic [1:0]                    es_size,
  input  logic [ADDR_W-1:0]             es_addr,
  input  logic [XLEN-1:0]               es_st_data,
  input  logic                          es_leave,
  input  logic                          flush,
  output logic                          mem_ready_go,
  output logic                          ale,
  output logic                          data_sram_req,
  output logic                          data_sram_wr,
  output logic [1:0]                    data_sram_size,
  output logic [ADDR_W-1:0]             data_sram_addr,
  output logic [XLEN/8-1:0]             data_sram_wstrb,
  output logic [XLEN-1:0]               data_sram_wdata,
  input  logic                          data_sram_addr_ok,
  input  logic                          data_sram_data_ok,
  output logic [$clog2(XLEN/8)-1:0]     ms_addr_lo,
  output logic                          req_cancel,
  output logic [2:0]                    outst_cnt
);

  localparam int         BYTES    = XLEN / 8;
  localparam int         OFF_W    = $clog2(BYTES);
  localparam logic [1:0] MAX_SIZE = 2'(OFF_W);
  localparam logic [2:0] MAX_CNT  = 3'(MAX_OUTST);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_e;

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               cancel_q, cancel_d;

  logic               mem_op;
  logic               start;
  logic [OFF_W-1:0]   addr_lo;
  logic [2:0]         align_mask;
  logic [7:0]         size_strb;
  logic [BYTES-1:0]   base_strb;

  assign mem_op     = es_valid & es_mem_en;
  assign addr_lo    = es_addr[OFF_W-1:0];
  assign ms_addr_lo = addr_lo;

  // Per-size low-address mask (alignment) and unshifted strobe pattern.
  always_comb begin
    align_mask = 3'b000;
    size_strb  = 8'h01;
    case (es_size)
      2'd0:    begin align_mask = 3'b000; size_strb = 8'h01; end
      2'd1:    begin align_mask = 3'b001; size_strb = 8'h03; end
      2'd2:    begin align_mask = 3'b011; size_strb = 8'h0F; end
      default: begin align_mask = 3'b111; size_strb = 8'hFF; end
    endcase
  end

  assign base_strb = size_strb[BYTES-1:0];

  // A size wider than the data path is as illegal as a misaligned address.
  assign ale   = mem_op & ((es_size > MAX_SIZE) | (|(addr_lo & align_mask[OFF_W-1:0])));
  assign start = mem_op & ~ale & ~flush & (cnt_q < MAX_CNT);

  assign data_sram_wr    = es_mem_we;
  assign data_sram_size  = es_size;
  assign data_sram_addr  = es_addr;
  assign data_sram_wstrb = es_mem_we ? (base_strb << addr_lo) : '0;

  // Replicate the size-wide LSB chunk so every byte lane carries it.
  always_comb begin
    data_sram_wdata = es_st_data;
    case (es_size)
      2'd0:    data_sram_wdata = {BYTES{es_st_data[7:0]}};
      2'd1:    data_sram_wdata = {(BYTES/2){es_st_data[15:0]}};
      2'd2:    data_sram_wdata = {(BYTES/4){es_st_data[31:0]}};
      default: data_sram_wdata = es_st_data;
    endcase
  end

  // State, outstanding counter and cancel pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cancel_q <= cancel_d;
    end
  end

  // Next-state logic. A flush after acceptance still lets the request complete
  // on the bus; MEM is told to discard its response through req_cancel.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = REQ;
      REQ: begin
        if (data_sram_addr_ok)  state_d = flush ? IDLE : DONE;
        else if (flush)         state_d = DRAIN;
      end
      DRAIN: if (data_sram_addr_ok) state_d = IDLE;
      DONE:  if (flush || es_leave) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and the cancel request that becomes a pulse one cycle later.
  always_comb begin
    data_sram_req = (state_q == REQ) || (state_q == DRAIN);
    mem_ready_go  = ~mem_op | ale | (state_q == DONE);
    cancel_d      = 1'b0;
    case (state_q)
      REQ:     cancel_d = flush & data_sram_addr_ok;
      DRAIN:   cancel_d = data_sram_addr_ok;
      DONE:    cancel_d = flush;
      default: cancel_d = 1'b0;
    endcase
  end

  // A data_ok with nothing outstanding is ignored so the count cannot wrap.
  always_comb begin
    logic inc, dec;
    inc   = data_sram_req & data_sram_addr_ok;
    dec   = data_sram_data_ok & (cnt_q != 3'd0);
    cnt_d = cnt_q;
    if (inc && !dec)      cnt_d = cnt_q + 3'd1;
    else if (dec && !inc) cnt_d = cnt_q - 3'd1;
  end

  assign req_cancel = cancel_q;
  assign outst_cnt  = cnt_q;

endmodule
